video_pattern_gen: RTL and testbench

Video source that produces the raster stream consumed by the 3x3 filter pipeline: `o_HSYNC`, `o_VSYNC`, `o_BLANK` and 8-bit luma `o_Y0`, with parameterised VGA timing. It sits upstream of `matrix_generator`/`median_filter` and replaces the camera or frame-buffer source for bring-up and regression.
- It generates gray ramps, a checkerboard or a per-frame flat level.
- It can inject LFSR salt-and-pepper impulses, so the median path can be checked on hardware.

---
 rtl/video_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_video_pattern_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Raster test source: VGA-style sync/blank timing plus 8-bit luma patterns
// (h-ramp, v-ramp, checker, flat frame count) with optional LFSR impulse noise.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   i_en            run request; a frame in progress always completes
//   i_mode          0 h-ramp, 1 v-ramp, 2 checker, 3 flat frame count
//   i_noise_en      salt-and-pepper injection enable
//   o_HSYNC/o_VSYNC sync outputs, asserted level given by SYNC_POL
//   o_BLANK         1 during active video
//   o_Y0            luma, forced to 0 outside active video
//   o_frame_start   one-clock pulse aligned with pixel (0,0)
module video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_mode,
    input  logic       i_noise_en,
    output logic       o_HSYNC,
    output logic       o_VSYNC,
    output logic       o_BLANK,
    output logic [7:0] o_Y0,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [0:0]    state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [1:0]    mode_q;
    logic          noise_q;
    logic [7:0]    frame_cnt;
    logic [15:0]   lfsr;

    logic [31:0] hx;
    logic [31:0] vx;
    logic        running;
    logic        h_last;
    logic        v_last;
    logic        active;
    logic        hs_on;
    logic        vs_on;
    logic        at_origin;
    logic        lfsr_fb;
    logic [7:0]  pat;
    logic [7:0]  pix;

    always_comb begin
        hx        = 32'(h);
        vx        = 32'(v);
        running   = (state == S_RUN);
        h_last    = (hx == H_TOTAL - 1);
        v_last    = (vx == V_TOTAL - 1);
        active    = (hx < H_ACTIVE) && (vx < V_ACTIVE);
        hs_on     = (hx >= H_ACTIVE + H_FP) &&
                    (hx < H_ACTIVE + H_FP + H_SYNC);
        vs_on     = (vx >= V_ACTIVE + V_FP) &&
                    (vx < V_ACTIVE + V_FP + V_SYNC);
        at_origin = (h == '0) && (v == '0);
        // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
        lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

        pat = 8'h00;
        unique case (mode_q)
            2'd0: pat = hx[7:0];
            2'd1: pat = vx[7:0];
            2'd2: pat = (hx[5] ^ vx[5]) ? 8'hFF : 8'h00;
            2'd3: pat = frame_cnt;
        endcase

        // Impulses use the LFSR value before this pixel's step.
        pix = pat;
        if (noise_q) begin
            if (lfsr[7:0] == 8'h00) begin
                pix = 8'hFF;
            end else if (lfsr[7:0] == 8'hFF) begin
                pix = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            h             <= '0;
            v             <= '0;
            mode_q        <= 2'd0;
            noise_q       <= 1'b0;
            frame_cnt     <= 8'd0;
            lfsr          <= 16'hACE1;
            o_HSYNC       <= ~SYNC_ON;
            o_VSYNC       <= ~SYNC_ON;
            o_BLANK       <= 1'b0;
            o_Y0          <= 8'h00;
            o_frame_start <= 1'b0;
        end else begin
            // Outputs describe this cycle's position: uniform 1-clock latency.
            o_HSYNC       <= (running && hs_on) ? SYNC_ON : ~SYNC_ON;
            o_VSYNC       <= (running && vs_on) ? SYNC_ON : ~SYNC_ON;
            o_BLANK       <= running && active;
            o_Y0          <= (running && active) ? pix : 8'h00;
            o_frame_start <= running && at_origin;

            unique case (state)
                S_IDLE: begin
                    if (i_en) begin
                        state   <= S_RUN;
                        mode_q  <= i_mode;
                        noise_q <= i_noise_en;
                    end
                end
                S_RUN: begin
                    if (noise_q && active) begin
                        lfsr <= {lfsr[14:0], lfsr_fb};
                    end
                    if (h_last) begin
                        h <= '0;
                        if (v_last) begin
                            v         <= '0;
                            frame_cnt <= frame_cnt + 8'd1;
                            // Frame boundary: the only place the run may stop
                            // or pick up new pattern settings.
                            if (i_en) begin
                                mode_q  <= i_mode;
                                noise_q <= i_noise_en;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            v <= v + VW'(1);
                        end
                    end else begin
                        h <= h + HW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: small-raster timing, modes,
// mode latching, stop/restart, impulse noise, async reset, default timing.
module tb_video_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd3;
    logic       noise = 1'b0;
    logic       hs, vs, blank, fs;
    logic [7:0] y;

    logic       en_big = 1'b0;
    logic       mode_big = 1'b0;
    logic       hs_b, vs_b, blank_b, fs_b;
    logic [7:0] y_b;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [7:0]  m_fc = 8'd0;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .i_en(en),
        .i_mode(mode),
        .i_noise_en(noise),
        .o_HSYNC(hs),
        .o_VSYNC(vs),
        .o_BLANK(blank),
        .o_Y0(y),
        .o_frame_start(fs)
    );

    video_pattern_gen u_big (
        .clk(clk),
        .rst(rst),
        .i_en(en_big),
        .i_mode({mode_big, mode_big}),
        .i_noise_en(mode_big),
        .o_HSYNC(hs_b),
        .o_VSYNC(vs_b),
        .o_BLANK(blank_b),
        .o_Y0(y_b),
        .o_frame_start(fs_b)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic chk(input string tag, input int p,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at %0d: observed %0h expected %0h",
                   tag, p, obs, exp);
        end
    endtask

    // Called at the sample where pixel (0,0) is on the outputs; checks one
    // 14x7 frame and leaves on the sample after its last pixel.
    task automatic run_frame(input int md, input bit nz,
                             input int chg_at, input logic [2:0] chg,
                             input int off_at, input int stop_at);
        int hh;
        int vv;
        logic act;
        logic [7:0] ey;
        for (int p = 0; p < 98; p++) begin
            if (p == stop_at) return;
            hh  = p % 14;
            vv  = p / 14;
            act = (hh < 8) && (vv < 4);
            case (md)
                0: ey = 8'(hh);
                1: ey = 8'(vv);
                2: ey = ((((hh >> 5) ^ (vv >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
                default: ey = m_fc;
            endcase
            if (act && nz) begin
                if (m_lfsr[7:0] == 8'h00) ey = 8'hFF;
                else if (m_lfsr[7:0] == 8'hFF) ey = 8'h00;
                m_lfsr = lfsr_next(m_lfsr);
            end
            if (!act) ey = 8'h00;
            chk("blank", p, 32'(blank), 32'(act));
            chk("y", p, 32'(y), 32'(ey));
            chk("hsync", p, 32'(hs), (hh == 10 || hh == 11) ? 0 : 1);
            chk("vsync", p, 32'(vs), (vv == 5) ? 0 : 1);
            chk("fstart", p, 32'(fs), (p == 0) ? 1 : 0);
            if (p == chg_at) {noise, mode} = chg;
            if (p == off_at) en = 1'b0;
            @(negedge clk);
        end
        m_fc = m_fc + 8'd1;
    endtask

    int bact, bhs_first, bhs_cnt, bvs_cnt;

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hsync", 0, 32'(hs), 1);
        chk("rst_vsync", 0, 32'(vs), 1);
        chk("rst_blank", 0, 32'(blank), 0);
        chk("rst_y", 0, 32'(y), 0);
        chk("rst_fstart", 0, 32'(fs), 0);

        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_blank", 0, 32'(blank), 0);
        chk("idle_fstart", 0, 32'(fs), 0);

        en = 1'b1;
        @(negedge clk);
        chk("start_wait", 0, 32'(fs), 0);
        @(negedge clk);

        run_frame(3, 0, -1, 3'b000, -1, -1);
        run_frame(3, 0, 45, 3'b001, -1, -1);
        run_frame(1, 0, 45, 3'b000, -1, -1);
        run_frame(0, 0, -1, 3'b000, 30, -1);

        for (int i = 0; i < 3; i++) begin
            chk("stop_hsync", i, 32'(hs), 1);
            chk("stop_vsync", i, 32'(vs), 1);
            chk("stop_blank", i, 32'(blank), 0);
            chk("stop_y", i, 32'(y), 0);
            chk("stop_fstart", i, 32'(fs), 0);
            @(negedge clk);
        end

        mode  = 2'd2;
        noise = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        chk("restart_wait", 0, 32'(fs), 0);
        @(negedge clk);

        run_frame(2, 1, -1, 3'b000, -1, -1);
        run_frame(2, 1, 50, 3'b100, -1, -1);
        for (int i = 0; i < 30; i++) begin
            run_frame(0, 1, (i == 29) ? 50 : -1, 3'b011, -1, -1);
        end

        run_frame(3, 0, -1, 3'b000, -1, 33);
        chk("pre_rst_blank", 33, 32'(blank), 1);
        chk("pre_rst_y", 33, 32'(y), 32'(m_fc));
        rst = 1'b1;
        #1;
        chk("async_hsync", 0, 32'(hs), 1);
        chk("async_vsync", 0, 32'(vs), 1);
        chk("async_blank", 0, 32'(blank), 0);
        chk("async_y", 0, 32'(y), 0);
        chk("async_fstart", 0, 32'(fs), 0);
        m_lfsr = 16'hACE1;
        m_fc   = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_restart_wait", 0, 32'(fs), 0);
        @(negedge clk);
        run_frame(3, 0, -1, 3'b000, -1, -1);
        run_frame(3, 0, -1, 3'b000, -1, -1);

        en_big = 1'b1;
        @(negedge clk);
        chk("big_wait", 0, 32'(fs_b), 0);
        @(negedge clk);
        bact = 0;
        bhs_first = -1;
        bhs_cnt = 0;
        bvs_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (i == 0) chk("big_fstart", i, 32'(fs_b), 1);
            if (i == 300) chk("big_y", i, 32'(y_b), 32'h2C);
            if (blank_b) bact++;
            if (!hs_b) begin
                if (bhs_first < 0) bhs_first = i;
                bhs_cnt++;
            end
            if (!vs_b) bvs_cnt++;
            @(negedge clk);
        end
        chk("big_active", 0, bact, 640);
        chk("big_hs_start", 0, bhs_first, 656);
        chk("big_hs_width", 0, bhs_cnt, 96);
        chk("big_vs_line0", 0, bvs_cnt, 0);
        chk("big_line1_blank", 800, 32'(blank_b), 1);
        chk("big_line1_fstart", 800, 32'(fs_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
